// File: rtl/int_dispatch.sv
// rtl/int_dispatch.sv - interrupt arbiter and dispatcher with IME/EI handling
module int_dispatch #(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
    input  logic               clk4_2,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               ime_set,
    input  logic               ime_set_now,
    input  logic               ime_reset,
    input  logic               instr_boundary,
    input  logic               dispatch_ack,
    output logic               IME,
    output logic               dispatch_req,
    output logic [15:0]        vector,
    output logic [NUM_IRQ-1:0] irq_clear,
    output logic               wake
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               ime_q, ime_d;
    logic               ei_q, ei_d;
    logic               wake_q;
    logic               ack_taken;
    logic [NUM_IRQ-1:0] active;
    logic [2:0]         lowest;
    logic [15:0]        offset;

    assign active = irq_req & irq_en;
    assign offset = {13'b0, idx_q} * VEC_STRIDE;
    assign IME    = ime_q;
    assign wake   = wake_q;

    // Lowest-index active channel wins; scanning downward lets low bits overwrite.
    always_comb begin
        lowest = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                lowest = 3'(i);
            end
        end
    end

    // Dispatch FSM next-state and outputs; the latched channel is frozen until CLEAR.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dispatch_req = 1'b0;
        vector       = 16'h0000;
        irq_clear    = '0;
        ack_taken    = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_boundary && ime_q && (|active)) begin
                    state_d = PENDING;
                    idx_d   = lowest;
                end
            end
            PENDING: begin
                dispatch_req = 1'b1;
                vector       = VEC_BASE + offset;
                if (dispatch_ack) begin
                    state_d   = CLEAR;
                    ack_taken = 1'b1;
                end
            end
            CLEAR: begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    irq_clear[i] = (idx_q == 3'(i));
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // IME / delayed-EI next state: dispatch entry clears everything, then DI > RETI > EI.
    always_comb begin
        ime_d = ime_q;
        ei_d  = ei_q;
        if (ei_q && instr_boundary) begin
            ime_d = 1'b1;
            ei_d  = 1'b0;
        end
        if (ime_set) begin
            ei_d = 1'b1;
        end
        if (ime_set_now) begin
            ime_d = 1'b1;
            ei_d  = 1'b0;
        end
        if (ime_reset) begin
            ime_d = 1'b0;
            ei_d  = 1'b0;
        end
        if (ack_taken) begin
            ime_d = 1'b0;
            ei_d  = 1'b0;
        end
    end

    // State registers; reset aborts any dispatch in flight without a clear pulse.
    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            ime_q   <= 1'b0;
            ei_q    <= 1'b0;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ime_q   <= ime_d;
            ei_q    <= ei_d;
            wake_q  <= |active;
        end
    end

endmodule

// File: tb/tb_int_dispatch.sv
// tb/tb_int_dispatch.sv - randomized scoreboard bench for int_dispatch
module tb_int_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [4:0]  req, en;
    logic        s_set, s_now, s_rst, s_bnd, s_ack;
    logic        ime_o, dreq_o, wake_o;
    logic [15:0] vec_o;
    logic [4:0]  clr_o;

    logic [7:0]  b_req, b_en, b_clr;
    logic        b_now, b_bnd, b_ack;
    logic        b_ime, b_dreq, b_wake;
    logic [15:0] b_vec;

    int_dispatch dut (
        .clk4_2(clk), .reset_n(reset_n), .irq_req(req), .irq_en(en),
        .ime_set(s_set), .ime_set_now(s_now), .ime_reset(s_rst),
        .instr_boundary(s_bnd), .dispatch_ack(s_ack),
        .IME(ime_o), .dispatch_req(dreq_o), .vector(vec_o),
        .irq_clear(clr_o), .wake(wake_o)
    );

    int_dispatch #(.NUM_IRQ(8), .VEC_BASE(16'hFFF8), .VEC_STRIDE(16'h0004)) dut8 (
        .clk4_2(clk), .reset_n(reset_n), .irq_req(b_req), .irq_en(b_en),
        .ime_set(1'b0), .ime_set_now(b_now), .ime_reset(1'b0),
        .instr_boundary(b_bnd), .dispatch_ack(b_ack),
        .IME(b_ime), .dispatch_req(b_dreq), .vector(b_vec),
        .irq_clear(b_clr), .wake(b_wake)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] vec;
        logic [4:0]  mask;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;

    bit m_ime, m_ei, m_wake;
    int m_phase;
    bit prev_dreq;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_of(input logic [4:0] a);
        for (int i = 0; i < 5; i++) begin
            if (a[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ime   = 0;
        m_ei    = 0;
        m_wake  = 0;
        m_phase = 0;
        sbq.delete();
    endtask

    // One clock of the spec rules applied to the inputs sampled at this edge.
    task automatic model_step();
        logic [4:0] act;
        bit         drop_ime;
        bit         old_ei;
        int         ch;
        exp_t       e;
        act      = req & en;
        drop_ime = 0;
        old_ei   = m_ei;
        if (m_phase == 0) begin
            if (s_bnd && m_ime && act != 0) begin
                ch     = lowest_of(act);
                e.vec  = 16'(32'h0040 + ch * 8);
                e.mask = 5'(1 << ch);
                sbq.push_back(e);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (s_ack) begin
                m_phase  = 2;
                drop_ime = 1;
            end
        end else begin
            m_phase = 0;
        end
        if (drop_ime || s_rst) begin
            m_ime = 0;
            m_ei  = 0;
        end else if (s_now) begin
            m_ime = 1;
            m_ei  = 0;
        end else begin
            if (old_ei && s_bnd) begin
                m_ime = 1;
                m_ei  = 0;
            end
            if (s_set) m_ei = 1;
        end
        m_wake = (act != 0);
    endtask

    task automatic cyc(input bit s, input bit n, input bit r, input bit b, input bit a,
                       input bit do_reset = 0);
        s_set = s; s_now = n; s_rst = r; s_bnd = b; s_ack = a;
        if (do_reset) begin
            reset_n = 1'b0;
            model_reset();
        end else begin
            reset_n = 1'b1;
        end
        @(posedge clk);
        if (reset_n) model_step();
        else model_reset();
        #1;
    endtask

    // Monitor: pops the scoreboard when a dispatch appears and checks every output.
    always @(negedge clk) begin
        if (dreq_o && !prev_dreq) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_dispatch: got vector %h expected none at %0t", vec_o, $time);
            end else begin
                cur = sbq.pop_front();
            end
        end
        prev_dreq = dreq_o;
        chk("ime", {15'b0, ime_o}, {15'b0, m_ime});
        chk("wake", {15'b0, wake_o}, {15'b0, m_wake});
        chk("dispatch_req", {15'b0, dreq_o}, {15'b0, (m_phase == 1)});
        chk("vector", vec_o, (m_phase == 1) ? cur.vec : 16'h0000);
        chk("irq_clear", {11'b0, clr_o}, (m_phase == 2) ? {11'b0, cur.mask} : 16'h0000);
    end

    initial begin
        bit found;
        bit rs, rn, rr, rb, ra, rd;
        reset_n = 1'b0;
        req = '0; en = '0;
        s_set = 0; s_now = 0; s_rst = 0; s_bnd = 0; s_ack = 0;
        b_req = '0; b_en = '0; b_now = 0; b_bnd = 0; b_ack = 0;
        cur = '{16'h0000, 5'b0};
        prev_dreq = 0;
        model_reset();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // priority: channel 2 of 5'b10100, ack together with RETI still drops IME
        cyc(0, 1, 0, 0, 0);
        req = 5'b10100; en = 5'b11111;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // EI delay: first boundary raises IME, second dispatches
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // masking and wake
        cyc(0, 0, 1, 0, 0);
        req = 5'b00001; en = 5'b00000;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        en = 5'b00001;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // stall with changing requests
        cyc(0, 1, 0, 0, 0);
        req = 5'b01000; en = 5'b11111;
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            req = 5'($urandom);
            cyc(0, 0, 0, 1, 0);
        end
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // collision and reset mid-PENDING
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        req = 5'b00010;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) req = 5'($urandom);
            if ($urandom_range(0, 7) == 0) en = 5'($urandom);
            rs = ($urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 14) == 0);
            rr = ($urandom_range(0, 14) == 0);
            rb = ($urandom_range(0, 2) == 0);
            ra = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 99) == 0);
            if (m_phase != 0) rb = 0;
            if (m_ei && rb) rs = 0;
            cyc(rs, rn, rr, rb, ra, rd);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);

        // wide instance: channel 7, vector wraps modulo 2^16
        req = '0; en = '0;
        b_now = 1;
        cyc(0, 0, 0, 0, 0);
        b_now = 0; b_req = 8'h80; b_en = 8'hFF; b_bnd = 1;
        cyc(0, 0, 0, 0, 0);
        b_bnd = 0;
        found = 0;
        for (int k = 0; k < 5; k++) begin
            if (b_dreq) begin
                found = 1;
                break;
            end
            cyc(0, 0, 0, 0, 0);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL dut8_dispatch_timeout: got no dispatch_req expected one within 5 cycles");
        end
        chk("dut8_vector", b_vec, 16'h0014);
        b_ack = 1;
        cyc(0, 0, 0, 0, 0);
        b_ack = 0;
        chk("dut8_irq_clear", {8'b0, b_clr}, 16'h0080);
        chk("dut8_ime", {15'b0, b_ime}, 16'h0000);
        cyc(0, 0, 0, 0, 0);
        chk("dut8_irq_clear_once", {8'b0, b_clr}, 16'h0000);
        chk("dut8_dispatch_req_low", {15'b0, b_dreq}, 16'h0000);

        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending dispatches expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
